// File: rtl/ultrasound_pkg.sv
// rtl/ultrasound_pkg.sv - shared ultrasound types and constants
package ultrasound_pkg;

   typedef enum logic [1:0] {IDLE, BLANK, LISTEN, DIVIDE} state_t;

   localparam int CLK_HZ        = 5_000_000;
   localparam int CYCLES_PER_CM = 65;
   // Pipeline delay of the echo synchronizer, removed from the measured tof.
   localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for the asynchronous echo input
module sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/echo_ranger.sv
// rtl/echo_ranger.sv - echo time-of-flight measurement and depth conversion
module echo_ranger
   import ultrasound_pkg::*;
#(
   parameter int CYCLES_PER_CM = ultrasound_pkg::CYCLES_PER_CM,
   parameter int MAX_CYCLES    = 2000,
   parameter int BLANK_CYCLES  = 65,
   parameter int MIN_PULSE     = 3,
   parameter int TOF_W         = 11,
   parameter int DEPTH_W       = 6
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               transmit,
   input  logic               receive,
   input  logic               echo,
   output logic [DEPTH_W-1:0] depth,
   output logic               depth_valid,
   output logic               no_echo,
   output logic               busy
);

   localparam int RUN_W = $clog2(MIN_PULSE + 1);

   state_t             state, state_next;
   logic               echo_s;
   logic [TOF_W-1:0]   tof, first_tof, rem, quo;
   logic [RUN_W-1:0]   run;
   logic               start, hit, timeout, done;

   sync2 u_sync (
      .clock (clock),
      .reset (reset),
      .d     (echo),
      .q     (echo_s)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // A transmit in any state restarts the shot; hit is checked before timeout.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      hit        = 1'b0;
      timeout    = 1'b0;
      done       = 1'b0;
      if (transmit) begin
         state_next = BLANK;
         start      = 1'b1;
      end else begin
         case (state)
            IDLE: ;
            BLANK:
               if (tof == TOF_W'(BLANK_CYCLES - 1)) state_next = LISTEN;
            LISTEN:
               if (run == RUN_W'(MIN_PULSE)) begin
                  hit        = 1'b1;
                  state_next = DIVIDE;
               end else if (tof == TOF_W'(MAX_CYCLES - 1) || !receive) begin
                  timeout    = 1'b1;
                  state_next = IDLE;
               end
            DIVIDE:
               if (rem < TOF_W'(CYCLES_PER_CM)) begin
                  done       = 1'b1;
                  state_next = IDLE;
               end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tof         <= '0;
         run         <= '0;
         first_tof   <= '0;
         rem         <= '0;
         quo         <= '0;
         depth       <= '0;
         depth_valid <= 1'b0;
         no_echo     <= 1'b0;
      end else begin
         depth_valid <= done;
         no_echo     <= timeout;

         if (start)                         tof <= '0;
         else if (tof != TOF_W'(MAX_CYCLES)) tof <= tof + 1'b1;

         if (start || hit)        run <= '0;
         else if (state == LISTEN) run <= echo_s ? run + 1'b1 : '0;

         if (state == LISTEN && echo_s && run == '0) first_tof <= tof;

         if (hit) begin
            rem <= first_tof - TOF_W'(SYNC_STAGES);
            quo <= '0;
         end else if (state == DIVIDE && rem >= TOF_W'(CYCLES_PER_CM)) begin
            rem <= rem - TOF_W'(CYCLES_PER_CM);
            quo <= quo + 1'b1;
         end

         if (done) begin
            if (quo > TOF_W'(2**DEPTH_W - 1)) depth <= '1;
            else                              depth <= quo[DEPTH_W-1:0];
         end
      end
   end

   // Stays high through the result pulse so it falls the cycle after it.
   assign busy = (state != IDLE) || depth_valid || no_echo;

endmodule

// File: doc/echo_ranger.md
# echo_ranger

Receive-side companion to the ultrasound pulse sequencer. It listens to the comparator-thresholded transducer echo during each receive window and measures the time of flight from the transmit pulse to the first qualified echo. It converts that time to depth in whole centimetres, at 65 cycles per cm on the 5 MHz clock. It sits beside the sequencer in `ultrasound` and consumes the same `transmit`/`receive` strobes.

## Interface
- `CYCLES_PER_CM`, 65: clock cycles of round-trip time per cm of depth.
- `MAX_CYCLES`, 2000: length of the listen window, in cycles after `transmit`.
- `BLANK_CYCLES`, 65: ring-down blanking; echo is ignored while tof < BLANK_CYCLES.
- `MIN_PULSE`, 3: number of consecutive high synchronized echo samples that qualify a hit.
- `TOF_W`, 11: time-of-flight counter width; must satisfy 2^TOF_W > MAX_CYCLES.
- `DEPTH_W`, 6: width of the depth output.
- `clock` in 1: the 5 MHz sequencer clock.
- `reset` in 1: reset is synchronous, active-high; it applies on `clock` rising edge.
- `transmit` in 1: 1-cycle pulse from the sequencer that starts a shot.
- `receive` in 1: receive-window level from the sequencer.
- `echo` in 1: raw comparator output; asynchronous.
- `depth` out DEPTH_W: last measured depth in cm; held until the next result.
- `depth_valid` out 1: 1-cycle pulse when `depth` updates.
- `no_echo` out 1: 1-cycle pulse when a shot ends without a hit.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- `echo` passes through a 2-flop synchronizer to give `echo_s`.
- The tof counter is zeroed on the cycle after `transmit` is sampled high and increments every cycle; it saturates at MAX_CYCLES.
- The states are IDLE, BLANK, LISTEN and DIVIDE.
  - IDLE: waits for `transmit`, then goes to BLANK with tof=0 and the run counter cleared.
  - BLANK: goes to LISTEN when tof == BLANK_CYCLES-1; echo is ignored in this state.
  - LISTEN: the run counter increments while `echo_s`=1 and clears while `echo_s`=0.
    - Hit: the run counter reaches MIN_PULSE. Latch t_hit = (tof at the first high sample of the run) - 2; the subtraction of 2 compensates the synchronizer. Then go to DIVIDE.
    - Timeout: tof == MAX_CYCLES-1, or `receive` deasserts while in LISTEN. Pulse `no_echo`, leave `depth` unchanged, go to IDLE.
  - DIVIDE: computes the quotient by repeated subtraction. The remainder starts at t_hit and the quotient at 0.
    - Each cycle with remainder >= CYCLES_PER_CM: subtract CYCLES_PER_CM and increment the quotient.
    - When remainder < CYCLES_PER_CM: load `depth` with the quotient, pulse `depth_valid`, go to IDLE.
- `transmit` seen in any non-IDLE state aborts the current shot without a `depth_valid` or `no_echo` pulse and restarts BLANK with tof=0.
- Simultaneous hit qualification and timeout on the same cycle: the hit wins.
- A quotient greater than 2^DEPTH_W-1 saturates to all-ones. This cannot occur with the default parameters (maximum quotient 30).
- Reset clears all of the following: state to IDLE; tof, run counter, remainder, quotient and synchronizer flops to 0; `depth`=0; `depth_valid`=0; `no_echo`=0; `busy`=0. Reset mid-shot discards the shot and produces no pulse.

## Timing
- Latency from the raw `echo` rise to hit detection is 2 + MIN_PULSE cycles.
- DIVIDE takes floor(t_hit/CYCLES_PER_CM)+1 cycles; the maximum is 31 with the defaults.
- `depth_valid` is asserted on the same cycle that `depth` takes its new value, and never more than one cycle at a time.
- `busy` rises on the cycle after `transmit` is sampled. It falls on the cycle after `depth_valid` or `no_echo`.
- An echo that first goes high at tof=T (raw input, stable high for at least MIN_PULSE+2 cycles) yields depth = floor(T/CYCLES_PER_CM).
- A raw echo high for fewer than MIN_PULSE cycles is rejected.

## Structure
- A shared package `ultrasound_pkg` holds:
  - the state enum (IDLE, BLANK, LISTEN, DIVIDE);
  - constants CLK_HZ=5_000_000 and CYCLES_PER_CM=65, shared with the sequencer's z_on/markers logic;
  - the SYNC_STAGES=2 compensation constant.
- One sub-module, `sync2`: the 2-flop synchronizer with synchronous reset. Everything else stays in `echo_ranger`.

## Test plan
- Echo step at T=650, held 20 cycles → `depth_valid` pulse with `depth`=10; `busy` falls the next cycle.
- Echo at T=30, inside blanking, held 10 cycles; no further echo → `no_echo` pulse at tof=1999; `depth` keeps its prior value.
- Echo at T=1000 high for 2 cycles, then a second echo at T=1300 held 10 cycles → `depth`=20; the first burst is rejected.
- `receive` dropped at tof=500 with no echo → `no_echo` at that point; a second `transmit` at tof=300 of a shot → no pulse for the aborted shot, and the new shot's echo at T=130 gives `depth`=2.
- `reset` asserted during DIVIDE for a t_hit=1950 shot → next cycle: all outputs 0 and `busy`=0; no `depth_valid`.
- Echo at T=1997 held to the window end → `no_echo` fires and the hit is not qualified. Echo at T=1994 held → the hit qualifies on the last LISTEN cycle, wins over timeout, and gives `depth`=30.
